// File: rtl/axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_mem_responder
//
// AXI4 slave that terminates the 64-bit, 4-bit-ID memory port coming from the
// board-level address mapper and answers it from an internal byte-strobed RAM.
// One write burst and one read burst are serviced concurrently. Only INCR
// bursts of full 64-bit beats (up to 256 beats) are supported. IDs are echoed.
//
// Parameters
//   ADDR_W   : byte address width
//   MEM_LOG2 : log2 of the RAM size in bytes (word index = addr[MEM_LOG2-1:3])
//   BASE     : window base used by the optional range check
//
// Optional feature macro
//   AXI_MEM_RANGE_CHECK_EN : when defined, bursts whose upper address bits
//     differ from BASE are handshaken normally, but writes are dropped and
//     every response is DECERR (reads return zero data). When undefined, the
//     upper address bits are ignored and the RAM aliases across the space.
//
// Ports
//   clk, reset            : single clock, asynchronous active-high reset
//   s_axi_aw* / s_axi_w*  : write address and write data channels
//   s_axi_b*              : write response channel
//   s_axi_ar*             : read address channel
//   s_axi_r*              : read data channel
// -----------------------------------------------------------------------------
module axi_mem_responder #(
  parameter int                ADDR_W   = 36,
  parameter int                MEM_LOG2 = 16,
  parameter logic [ADDR_W-1:0] BASE     = 36'h8_0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  // write address
  input  logic [3:0]        s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  // write data
  input  logic [63:0]       s_axi_wdata,
  input  logic [7:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  // write response
  output logic [3:0]        s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  // read address
  input  logic [3:0]        s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  // read data
  output logic [63:0]       s_axi_rdata,
  output logic [3:0]        s_axi_rid,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int IDX_W = MEM_LOG2 - 3;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  // ---------------------------------------------------------------------------
  // Address window decode
  // ---------------------------------------------------------------------------
  logic aw_dec;
  logic ar_dec;
  logic unused_addr_bits;

`ifdef AXI_MEM_RANGE_CHECK_EN
  assign aw_dec = (s_axi_awaddr[ADDR_W-1:MEM_LOG2] != BASE[ADDR_W-1:MEM_LOG2]);
  assign ar_dec = (s_axi_araddr[ADDR_W-1:MEM_LOG2] != BASE[ADDR_W-1:MEM_LOG2]);
  assign unused_addr_bits = ^{s_axi_awaddr[2:0], s_axi_araddr[2:0]};
`else
  assign aw_dec = 1'b0;
  assign ar_dec = 1'b0;
  assign unused_addr_bits = ^{s_axi_awaddr[ADDR_W-1:MEM_LOG2], s_axi_awaddr[2:0],
                              s_axi_araddr[ADDR_W-1:MEM_LOG2], s_axi_araddr[2:0]};
`endif

  // Holds both address channels off for the first edge after reset release so
  // awready/arready are low throughout reset and rise on the first edge after.
  logic ready_en;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_t               w_state, w_state_next;
  logic [IDX_W-1:0]       w_idx;
  logic [7:0]             w_len;
  logic [7:0]             w_beat;
  logic                   w_err;
  logic                   w_dec;
  logic                   aw_hs, w_hs;
  logic                   w_last_beat;
  logic                   w_err_next;
  logic                   mem_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next  = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = ready_en;
        if (s_axi_awvalid && ready_en) w_state_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && w_last_beat) w_state_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  assign aw_hs       = s_axi_awvalid && s_axi_awready;
  assign w_hs        = s_axi_wvalid && s_axi_wready;
  // The beat count ends the burst; wlast is only checked against it.
  assign w_last_beat = (w_beat == w_len);
  assign w_err_next  = w_err | (s_axi_wlast != w_last_beat);
  assign mem_we      = w_hs && !w_dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_idx       <= '0;
      w_len       <= '0;
      w_beat      <= '0;
      w_err       <= 1'b0;
      w_dec       <= 1'b0;
      s_axi_bid   <= '0;
      s_axi_bresp <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        s_axi_bid <= s_axi_awid;
        w_idx     <= s_axi_awaddr[MEM_LOG2-1:3];
        w_len     <= s_axi_awlen;
        w_beat    <= '0;
        w_err     <= 1'b0;
        w_dec     <= aw_dec;
      end
      if (w_hs) begin
        w_idx  <= w_idx + 1'b1;  // wraps modulo the RAM depth
        w_beat <= w_beat + 1'b1;
        w_err  <= w_err_next;
        if (w_last_beat) begin
          if (w_dec)           s_axi_bresp <= RESP_DECERR;
          else if (w_err_next) s_axi_bresp <= RESP_SLVERR;
          else                 s_axi_bresp <= RESP_OKAY;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  logic [63:0] mem [DEPTH];

  // NOTE: the RAM array has no reset; contents must survive a reset pulse and
  // a resettable array could not map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_t         r_state, r_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_rem;     // beats left after the one being presented
  logic             r_dec;
  logic             ar_hs, r_hs;
  logic             rd_en;
  logic [IDX_W-1:0] rd_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_next;
  end

  always_comb begin
    r_state_next  = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = r_idx;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = ready_en;
        if (s_axi_arvalid && ready_en) r_state_next = R_FETCH;
      end
      R_FETCH: begin
        rd_en        = 1'b1;
        r_state_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) begin
          if (s_axi_rlast) begin
            r_state_next = R_IDLE;
          end else begin
            // Prefetch the next word so it is presented on the next cycle.
            rd_en   = 1'b1;
            rd_addr = r_idx + 1'b1;
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;

  // The read register only loads on rd_en, so rdata/rlast hold while stalled.
  // Its read of mem and the write above share an edge, giving read-first
  // behaviour for a same-cycle read and write of one word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_rem       <= '0;
      r_dec       <= 1'b0;
      s_axi_rid   <= '0;
      s_axi_rresp <= RESP_OKAY;
      s_axi_rlast <= 1'b0;
      s_axi_rdata <= '0;
    end else begin
      if (ar_hs) begin
        s_axi_rid   <= s_axi_arid;
        s_axi_rresp <= ar_dec ? RESP_DECERR : RESP_OKAY;
        r_idx       <= s_axi_araddr[MEM_LOG2-1:3];
        r_rem       <= s_axi_arlen;
        r_dec       <= ar_dec;
      end
      if (r_state == R_FETCH) s_axi_rlast <= (r_rem == 8'd0);
      if (r_hs) begin
        if (s_axi_rlast) begin
          s_axi_rlast <= 1'b0;
        end else begin
          r_idx       <= rd_addr;
          r_rem       <= r_rem - 8'd1;
          s_axi_rlast <= (r_rem == 8'd1);
        end
      end
      if (rd_en) s_axi_rdata <= r_dec ? 64'd0 : mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
`timescale 1ns/1ps
module tb_axi_mem_responder;

  localparam int          WORDS = 8192;
  localparam int          TMO   = 4000;
  localparam logic [35:0] BASE  = 36'h8_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  awid;    logic [35:0] awaddr; logic [7:0] awlen;
  logic        awvalid; logic        awready;
  logic [63:0] wdata;   logic [7:0]  wstrb;  logic wlast, wvalid, wready;
  logic [3:0]  bid;     logic [1:0]  bresp;  logic bvalid, bready;
  logic [3:0]  arid;    logic [35:0] araddr; logic [7:0] arlen;
  logic        arvalid; logic        arready;
  logic [63:0] rdata;   logic [3:0]  rid;    logic [1:0] rresp;
  logic        rlast, rvalid, rready;

  axi_mem_responder dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rid(rid), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  // Reference model: the RAM as a plain word array plus expected responses.
  typedef struct { logic [63:0] data; logic [3:0] id; logic [1:0] resp; logic last; } r_exp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;

  logic [63:0] model [WORDS];
  r_exp_t      exp_r[$];
  b_exp_t      exp_b[$];
  logic [63:0] got[$];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  logic [3:0]  last_bid;
  logic [1:0]  last_bresp;
  int          last_rlast_cyc;
  bit          rr_rand = 1'b0, br_rand = 1'b0, wv_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  function automatic bit in_win(input logic [35:0] a);
`ifdef AXI_MEM_RANGE_CHECK_EN
    return a[35:16] == BASE[35:16];
`else
    return 1'b1;
`endif
  endfunction

  function automatic int widx(input logic [35:0] a, input int beat);
    return (int'(a[15:3]) + beat) % WORDS;
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: every cycle, outputs against the model's expectations.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset) begin
      check("rst_awready", awready, 0); check("rst_wready", wready, 0);
      check("rst_bvalid", bvalid, 0);   check("rst_arready", arready, 0);
      check("rst_rvalid", rvalid, 0);   check("rst_rlast", rlast, 0);
      check("rst_bid", bid, 0);         check("rst_bresp", bresp, 0);
      check("rst_rid", rid, 0);         check("rst_rresp", rresp, 0);
      check("rst_rdata", rdata, 0);
    end else begin
      if (rvalid) begin
        if (exp_r.size() == 0) check("r_unexpected_beat", rvalid, 0);
        else begin
          check("rdata", rdata, exp_r[0].data);
          check("rid", rid, exp_r[0].id);
          check("rresp", rresp, exp_r[0].resp);
          check("rlast", rlast, exp_r[0].last);
          if (rready) begin
            got.push_back(rdata);
            if (rlast) last_rlast_cyc = cyc;
            void'(exp_r.pop_front());
          end
        end
      end
      if (bvalid) begin
        if (exp_b.size() == 0) check("b_unexpected", bvalid, 0);
        else begin
          check("bid", bid, exp_b[0].id);
          check("bresp", bresp, exp_b[0].resp);
          if (bready) begin
            last_bid   = bid;
            last_bresp = bresp;
            void'(exp_b.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rready = rr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers (start and end at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic do_write(input logic [3:0] id, input logic [35:0] addr, input int len,
                          input int bad_beat, output int aw_c, output int wr_c,
                          output int lw_c, output int bv_c);
    bit ok, hs, mism;
    int n, beat, wi;
    b_exp_t be;
    ok   = in_win(addr);
    mism = (bad_beat >= 0) && (bad_beat != len);
    be.id   = id;
    be.resp = !ok ? 2'b11 : (mism ? 2'b10 : 2'b00);
    exp_b.push_back(be);
    aw_c = -1; wr_c = -1; lw_c = -1; bv_c = -1;
    awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1; n = 0;
    forever begin
      @(negedge clk); hs = awready; aw_c = cyc;
      @(posedge clk); #1;
      if (hs) break;
      if (++n > TMO) begin timeout("aw_handshake"); break; end
    end
    awvalid = 1'b0;
    beat = 0; n = 0;
    while (beat <= len && n <= TMO) begin
      wvalid = (wv_rand && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      wdata  = wd[beat];
      wstrb  = ws[beat];
      wlast  = (bad_beat >= 0) ? (beat == bad_beat) : (beat == len);
      @(negedge clk);
      if (wready && wr_c < 0) wr_c = cyc;
      hs = wvalid && wready;
      if (hs) begin
        if (ok) begin
          wi = widx(addr, beat);
          for (int b = 0; b < 8; b++) if (ws[beat][b]) model[wi][8*b +: 8] = wd[beat][8*b +: 8];
        end
        lw_c = cyc;
        beat++;
      end
      @(posedge clk); #1;
      n++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (beat <= len) timeout("w_beats");
    n = 0;
    forever begin
      bready = br_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bvalid && bv_c < 0) bv_c = cyc;
      hs = bvalid && bready;
      @(posedge clk); #1;
      if (hs) break;
      if (++n > TMO) begin timeout("b_handshake"); break; end
    end
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [35:0] addr, input int len,
                         output int ar_c, output int rv_c, output int waits);
    bit ok, hs;
    int n;
    r_exp_t e;
    ok = in_win(addr);
    for (int i = 0; i <= len; i++) begin
      e.data = ok ? model[widx(addr, i)] : 64'd0;
      e.id   = id;
      e.resp = ok ? 2'b00 : 2'b11;
      e.last = (i == len);
      exp_r.push_back(e);
    end
    ar_c = -1; rv_c = -1;
    arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1; n = 0;
    forever begin
      @(negedge clk); hs = arready; ar_c = cyc;
      @(posedge clk); #1;
      if (hs) break;
      if (++n > TMO) begin timeout("ar_handshake"); break; end
    end
    waits = n;
    arvalid = 1'b0;
    n = 0;
    while (exp_r.size() > 0) begin
      @(negedge clk);
      if (rvalid && rv_c < 0) rv_c = cyc;
      @(posedge clk); #1;
      if (++n > TMO) begin timeout("r_beats"); exp_r.delete(); break; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int aw_c, wr_c, lw_c, bv_c, ar_c, rv_c, waits, base, n, len, bad;
    logic [35:0] a;
    awid = 0; awaddr = 0; awlen = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arvalid = 0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("awready_before_first_edge", awready, 0);
    check("arready_before_first_edge", arready, 0);
    @(posedge clk); #1;
    check("awready_after_first_edge", awready, 1);
    check("arready_after_first_edge", arready, 1);

    // Fill the whole RAM so every later read has a known expectation.
    for (int blk = 0; blk < 32; blk++) begin
      for (int i = 0; i < 256; i++) begin
        wd[i] = {16'hC0DE, 16'(blk), 32'(i)};
        ws[i] = 8'hFF;
      end
      do_write(4'(blk), BASE + 36'(blk * 2048), 255, -1, aw_c, wr_c, lw_c, bv_c);
    end

    // 4-beat write then read back, with latency checks.
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    do_write(4'd5, 36'h8_0000_0100, 3, -1, aw_c, wr_c, lw_c, bv_c);
    check("tp1_bid", last_bid, 4'd5);
    check("tp1_bresp", last_bresp, 2'b00);
    check("tp1_wready_latency", 64'(wr_c - aw_c), 1);
    check("tp1_bvalid_latency", 64'(bv_c - lw_c), 1);
    base = got.size();
    do_read(4'd9, 36'h8_0000_0100, 3, ar_c, rv_c, waits);
    check("tp1_rvalid_latency", 64'(rv_c - ar_c), 2);
    check("tp1_last_beat_cycle", 64'(last_rlast_cyc - ar_c), 5);
    check("tp1_beat0", got[base],   64'h11);
    check("tp1_beat1", got[base+1], 64'h22);
    check("tp1_beat2", got[base+2], 64'h33);
    check("tp1_beat3", got[base+3], 64'h44);

    // Partial strobe over a zero word.
    wd[0] = 64'd0; ws[0] = 8'hFF;
    do_write(4'd1, 36'h8_0000_0200, 0, -1, aw_c, wr_c, lw_c, bv_c);
    wd[0] = 64'hAAAAAAAA_BBBBBBBB; ws[0] = 8'h0F;
    do_write(4'd2, 36'h8_0000_0200, 0, -1, aw_c, wr_c, lw_c, bv_c);
    base = got.size();
    do_read(4'd3, 36'h8_0000_0200, 0, ar_c, rv_c, waits);
    check("tp2_strobe_merge", got[base], 64'h00000000_BBBBBBBB);

    // Early wlast on a 2-beat burst.
    wd[0] = 64'h77; wd[1] = 64'h88; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(4'd4, 36'h8_0000_0300, 1, 0, aw_c, wr_c, lw_c, bv_c);
    check("tp3_bresp_slverr", last_bresp, 2'b10);
    base = got.size();
    do_read(4'd4, 36'h8_0000_0300, 1, ar_c, rv_c, waits);
    check("tp3_beat1_written", got[base+1], 64'h88);

    // Wrap at the top of the RAM, randomised handshakes.
    wv_rand = 1'b1; br_rand = 1'b1; rr_rand = 1'b1;
    wd[0] = 64'hDEAD0001; wd[1] = 64'hDEAD0002;
    do_write(4'd1, 36'h8_0000_FFF8, 1, -1, aw_c, wr_c, lw_c, bv_c);
    base = got.size();
    do_read(4'd7, 36'h8_0000_FFF8, 255, ar_c, rv_c, waits);
    check("tp4_beat_count", 64'(got.size() - base), 256);
    check("tp4_beat0_top", got[base],   64'hDEAD0001);
    check("tp4_beat1_wrap", got[base+1], 64'hDEAD0002);
    check("tp4_beat2", got[base+2], 64'hC0DE0000_00000001);

    // Out-of-window access.
    wd[0] = 64'h5A5A5A5A_5A5A5A5A; ws[0] = 8'hFF;
    do_write(4'd3, 36'h9_0000_0000, 0, -1, aw_c, wr_c, lw_c, bv_c);
    base = got.size();
    do_read(4'd4, 36'h9_0000_0000, 0, ar_c, rv_c, waits);
    do_read(4'd4, 36'h8_0000_0000, 0, ar_c, rv_c, waits);
`ifdef AXI_MEM_RANGE_CHECK_EN
    check("tp5_bresp_decerr", last_bresp, 2'b11);
    check("tp5_read_zero", got[base], 64'd0);
    check("tp5_word0_kept", got[base+1], 64'hDEAD0002);
`else
    check("tp5_bresp_okay", last_bresp, 2'b00);
    check("tp5_alias_read", got[base], 64'h5A5A5A5A_5A5A5A5A);
    check("tp5_word0_aliased", got[base+1], 64'h5A5A5A5A_5A5A5A5A);
`endif

    // Reset during beat 2 of an 8-beat read.
    wv_rand = 1'b0; br_rand = 1'b0; rr_rand = 1'b0;
    @(posedge clk); #1;
    base = got.size();
    fork
      do_read(4'd2, 36'h8_0000_0100, 7, ar_c, rv_c, waits);
      begin
        n = 0;
        while (got.size() < base + 2 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timeout("rst_wait_beats");
        reset = 1'b1;
        exp_r.delete();
        #1 check("rst_mid_rvalid", rvalid, 0);
      end
    join
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_release_arready", arready, 0);
    base = got.size();
    do_read(4'd6, 36'h8_0000_0100, 3, ar_c, rv_c, waits);
    check("rst_ar_accept_waits", 64'(waits), 1);
    check("rst_data_kept0", got[base],   64'h11);
    check("rst_data_kept3", got[base+3], 64'h44);

    // Random traffic.
    wv_rand = 1'b1; br_rand = 1'b1; rr_rand = 1'b1;
    for (int it = 0; it < 24; it++) begin
      len = $urandom_range(0, 15);
      a   = BASE | (36'($urandom_range(0, WORDS - 1)) << 3);
      for (int i = 0; i <= len; i++) begin
        wd[i] = {$urandom, $urandom};
        ws[i] = 8'($urandom_range(0, 255));
      end
      bad = -1;
      if ($urandom_range(0, 4) == 0) bad = $urandom_range(0, 1) ? 99 : int'($urandom_range(0, len));
      do_write(4'($urandom), a, len, bad, aw_c, wr_c, lw_c, bv_c);
      if (it % 2 == 0) do_read(4'($urandom), a, len, ar_c, rv_c, waits);
      else do_read(4'($urandom), BASE | (36'($urandom_range(0, WORDS - 1)) << 3),
                   $urandom_range(0, 31), ar_c, rv_c, waits);
    end

    // Concurrent write (lower half) and read (upper half).
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(0, 15);
      for (int i = 0; i <= len; i++) begin
        wd[i] = {$urandom, $urandom};
        ws[i] = 8'($urandom_range(0, 255));
      end
      fork
        do_write(4'($urandom), BASE | (36'($urandom_range(0, 4079)) << 3), len, -1,
                 aw_c, wr_c, lw_c, bv_c);
        do_read(4'($urandom), BASE | (36'($urandom_range(4096, 8160)) << 3),
                $urandom_range(0, 31), ar_c, rv_c, waits);
      join
    end

    repeat (4) @(posedge clk);
    check("final_r_queue_empty", 64'(exp_r.size()), 0);
    check("final_b_queue_empty", 64'(exp_b.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 slave that terminates the 64-bit, 4-bit-ID memory port produced by the board-level address mapper and answers it from an internal byte-strobed RAM. It is the responder end of that interface. It lets the SoC memory path be exercised on the ZCU102 flow and in simulation without the PS DDR controller. It services one write burst and one read burst concurrently, echoes IDs, and supports INCR bursts up to 256 beats.

## Interface
- ADDR_W, 36, address width; matches the mapped address space.
- MEM_LOG2, 16, log2 of RAM size in bytes (default 64 KiB, i.e. 8192 64-bit words).
- BASE, 36'h8_0000_0000, window base used by the range check (see Configuration).
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- s_axi_awid  in  4  write burst ID.
- s_axi_awaddr  in  ADDR_W  write byte address; bits [2:0] ignored.
- s_axi_awlen  in  8  write beats minus one.
- s_axi_awvalid  in  1  AW valid.
- s_axi_awready  out  1  AW ready.
- s_axi_wdata  in  64  write data.
- s_axi_wstrb  in  8  byte enables.
- s_axi_wlast  in  1  last write beat from master.
- s_axi_wvalid  in  1  W valid.
- s_axi_wready  out  1  W ready.
- s_axi_bid  out  4  echoed AW ID.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  B valid.
- s_axi_bready  in  1  B ready.
- s_axi_arid  in  4  read burst ID.
- s_axi_araddr  in  ADDR_W  read byte address; bits [2:0] ignored.
- s_axi_arlen  in  8  read beats minus one.
- s_axi_arvalid  in  1  AR valid.
- s_axi_arready  out  1  AR ready.
- s_axi_rdata  out  64  read data.
- s_axi_rid  out  4  echoed AR ID.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  last read beat.
- s_axi_rvalid  out  1  R valid.
- s_axi_rready  in  1  R ready.

## Operation
- All beats are full 64-bit width; INCR bursts only. Size, burst, lock, cache, prot and qos are tied off upstream and are not ports.
- Word index = addr[MEM_LOG2-1:3]. It increments once per beat and wraps modulo 2^(MEM_LOG2-3) inside a burst.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. The AW handshake captures ID, index and beat count = awlen.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb. After awlen+1 beats, move to W_RESP.
  - W_RESP: bvalid=1, held stable until bready.
- Beat count, not wlast, ends the write burst. If wlast is seen on any beat other than beat awlen, or is missing on it, bresp=SLVERR (2'b10); otherwise OKAY (2'b00).
- Read FSM R_IDLE -> R_FETCH -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. The AR handshake captures ID, index and count.
  - R_FETCH: one synchronous RAM read.
  - R_DATA: rvalid=1. On each handshake the next word's read is issued, so the next beat is valid the following cycle. rlast is asserted on beat arlen.
- Read and write run independently. A same-cycle read and write to the same word returns the old data (read-first).

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, rid, bresp, rresp, rdata = 0. awready and arready rise on the first clk edge after reset deasserts.
- Reset asserted mid-burst aborts the burst immediately. RAM contents are preserved, and both FSMs return to idle.
- AW handshake at cycle N: wready=1 from N+1. Last W handshake at cycle M: bvalid=1 at M+1.
- AR handshake at cycle N: first rvalid at N+2. With rready held high, one beat per cycle follows, so a 4-beat read completes at N+5.
- While rvalid=1 and rready=0, rdata, rid, rresp and rlast are held. awready and arready are 0 outside their idle states.

## Configuration
- AXI_MEM_RANGE_CHECK_EN defined: a burst whose addr[ADDR_W-1:MEM_LOG2] differs from BASE[ADDR_W-1:MEM_LOG2] is still fully handshaken, but:
  - the write is suppressed and bresp is DECERR (2'b11);
  - reads return rdata=0 with rresp=DECERR on every beat.
- Not defined: upper address bits are ignored (the window aliases) and every response is OKAY, except SLVERR for a wlast mismatch.

## Test plan
- Write 4 beats (awlen=3) to 0x8_0000_0100, data 0x11..0x44, wstrb=0xFF, id=5. Read back with arlen=3, id=9 -> bid=5, bresp=0; rid=9, rresp=0, data 0x11..0x44, rlast only on beat 3.
- Write wstrb=0x0F of 0xAAAAAAAA_BBBBBBBB over a word holding 0 -> readback 0x00000000_BBBBBBBB.
- Write burst awlen=1 with wlast on beat 0 -> two beats accepted, bresp=2'b10.
- Read awlen=255 starting at the last word 0x8_0000_FFF8 -> beat 1 returns word 0 (wrap). Toggle rready randomly: no beat is lost or duplicated, and rdata is stable while stalled.
- With AXI_MEM_RANGE_CHECK_EN: access at 0x9_0000_0000 -> bresp=2'b11, RAM unchanged; read returns rdata=0, rresp=2'b11. Without the macro: same address aliases to word 0 with OKAY.
- Assert reset during beat 2 of an 8-beat read -> rvalid=0 while reset is held. A new AR is accepted on the first cycle after release, and earlier RAM data is intact.
